fan_pid_sequencer: RTL and testbench

//  Sequences the fan PID datapath once per programmable sample period: ADC req/valid handshake,

---
 rtl/fan_pid_sequencer.sv | 172 +++++++++++++++++
 tb/tb_fan_pid_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fan_pid_sequencer.sv
// Per-sample sequencer for the fan PID loop: sample-period tick, ADC handshake, PID step strobe,
// output capture and duty mapping, with shadowed coefficients that commit at sample boundaries.
module fan_pid_sequencer #(
    parameter int ADC_BITWIDTH      = 8,
    parameter int REG_BITWIDTH      = 5,
    parameter int PRESCALE_BITWIDTH = 16,
    parameter int ADC_TIMEOUT       = 255,
    parameter int OUT_POLARITY      = 1
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         en_i,
    input  logic [PRESCALE_BITWIDTH-1:0] period_i,
    output logic                         adc_req_o,
    input  logic                         adc_valid_i,
    input  logic [ADC_BITWIDTH-1:0]      adc_data_i,
    output logic [ADC_BITWIDTH-1:0]      adc_value_o,
    input  logic                         coef_wr_i,
    input  logic [2:0]                   coef_addr_i,
    input  logic [REG_BITWIDTH-1:0]      coef_data_i,
    output logic [REG_BITWIDTH-1:0]      a1_o,
    output logic [REG_BITWIDTH-1:0]      a0_o,
    output logic [REG_BITWIDTH-1:0]      b0_o,
    output logic [REG_BITWIDTH-1:0]      b1_o,
    output logic [REG_BITWIDTH-1:0]      b2_o,
    output logic                         clk_en_PID_o,
    input  logic [ADC_BITWIDTH:0]        pid_val_i,
    output logic [ADC_BITWIDTH-1:0]      duty_o,
    output logic                         duty_valid_o,
    output logic                         adc_timeout_o,
    output logic                         overrun_o
);

    localparam int TMR_W = (ADC_TIMEOUT < 2) ? 1 : $clog2(ADC_TIMEOUT + 1);
    localparam int NCOEF = 5;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        REQ       = 3'd2,
        STEP      = 3'd3,
        CAPTURE   = 3'd4
    } state_t;

    state_t                                 state_reg;
    logic [PRESCALE_BITWIDTH-1:0]           cnt_reg;
    logic [TMR_W-1:0]                       tmr_reg;
    logic [NCOEF-1:0][REG_BITWIDTH-1:0]     shadow_reg;
    logic [NCOEF-1:0][REG_BITWIDTH-1:0]     active_reg;
    logic                                   req_reg;
    logic                                   stb_reg;
    logic                                   dv_reg;
    logic                                   to_reg;
    logic                                   ov_reg;
    logic [ADC_BITWIDTH-1:0]                value_reg;
    logic [ADC_BITWIDTH-1:0]                duty_reg;

    logic                                   tick;
    logic                                   busy;
    logic [ADC_BITWIDTH+1:0]                pid_ext;
    logic [ADC_BITWIDTH+1:0]                pid_neg;
    logic [ADC_BITWIDTH-1:0]                duty_next;

    always_comb begin
        tick    = (cnt_reg == '0);
        busy    = (state_reg == REQ) || (state_reg == STEP) || (state_reg == CAPTURE);
        pid_ext = {pid_val_i[ADC_BITWIDTH], pid_val_i};
        // Negating at two extra bits keeps -2^ADC_BITWIDTH representable so it can saturate.
        pid_neg   = '0 - pid_ext;
        duty_next = '0;
        if (OUT_POLARITY != 0) begin
            if (pid_val_i[ADC_BITWIDTH])
                duty_next = pid_neg[ADC_BITWIDTH] ? '1 : pid_neg[ADC_BITWIDTH-1:0];
        end else begin
            if (!pid_val_i[ADC_BITWIDTH])
                duty_next = pid_val_i[ADC_BITWIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            shadow_reg <= '0;
        end else if (coef_wr_i) begin
            for (int i = 0; i < NCOEF; i++) begin
                if (coef_addr_i == 3'(i))
                    shadow_reg[i] <= coef_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            tmr_reg    <= '0;
            active_reg <= '0;
            req_reg    <= 1'b0;
            stb_reg    <= 1'b0;
            dv_reg     <= 1'b0;
            to_reg     <= 1'b0;
            ov_reg     <= 1'b0;
            value_reg  <= '0;
            duty_reg   <= '0;
        end else begin
            stb_reg <= 1'b0;
            dv_reg  <= 1'b0;
            to_reg  <= 1'b0;
            ov_reg  <= 1'b0;
            if (!en_i) begin
                state_reg <= IDLE;
                req_reg   <= 1'b0;
            end else if (state_reg == IDLE) begin
                cnt_reg   <= period_i;
                state_reg <= WAIT_TICK;
            end else begin
                cnt_reg <= tick ? period_i : cnt_reg - PRESCALE_BITWIDTH'(1);
                // A tick that arrives mid-sequence is reported and dropped.
                if (tick && busy)
                    ov_reg <= 1'b1;
                case (state_reg)
                    WAIT_TICK: begin
                        if (tick) begin
                            active_reg <= shadow_reg;
                            req_reg    <= 1'b1;
                            tmr_reg    <= '0;
                            state_reg  <= REQ;
                        end
                    end
                    REQ: begin
                        if (adc_valid_i) begin
                            value_reg <= adc_data_i;
                            req_reg   <= 1'b0;
                            stb_reg   <= 1'b1;
                            state_reg <= STEP;
                        end else if (tmr_reg == TMR_W'(ADC_TIMEOUT - 1)) begin
                            req_reg   <= 1'b0;
                            to_reg    <= 1'b1;
                            state_reg <= WAIT_TICK;
                        end else begin
                            tmr_reg <= tmr_reg + TMR_W'(1);
                        end
                    end
                    STEP: begin
                        state_reg <= CAPTURE;
                    end
                    CAPTURE: begin
                        duty_reg  <= duty_next;
                        dv_reg    <= 1'b1;
                        state_reg <= WAIT_TICK;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign adc_req_o     = req_reg;
    assign adc_value_o   = value_reg;
    assign clk_en_PID_o  = stb_reg;
    assign duty_o        = duty_reg;
    assign duty_valid_o  = dv_reg;
    assign adc_timeout_o = to_reg;
    assign overrun_o     = ov_reg;
    assign a1_o          = active_reg[0];
    assign a0_o          = active_reg[1];
    assign b0_o          = active_reg[2];
    assign b1_o          = active_reg[3];
    assign b2_o          = active_reg[4];

endmodule

// File: tb/tb_fan_pid_sequencer.sv
// Randomized bench for fan_pid_sequencer: a sample-schedule model predicts every output each cycle.
module tb_fan_pid_sequencer;

    localparam int AW = 8;
    localparam int RW = 5;
    localparam int PW = 16;
    localparam int TO = 4;
    localparam int NSLOT = 8192;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          en_i;
    logic [PW-1:0] period_i;
    logic          adc_req_o;
    logic          adc_valid_i;
    logic [AW-1:0] adc_data_i;
    logic [AW-1:0] adc_value_o;
    logic          coef_wr_i;
    logic [2:0]    coef_addr_i;
    logic [RW-1:0] coef_data_i;
    logic [RW-1:0] a1_o, a0_o, b0_o, b1_o, b2_o;
    logic          clk_en_PID_o;
    logic [AW:0]   pid_val_i;
    logic [AW-1:0] duty_o;
    logic          duty_valid_o;
    logic          adc_timeout_o;
    logic          overrun_o;

    always #5 clk_i = ~clk_i;

    fan_pid_sequencer #(
        .ADC_BITWIDTH(AW), .REG_BITWIDTH(RW), .PRESCALE_BITWIDTH(PW),
        .ADC_TIMEOUT(TO), .OUT_POLARITY(1)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .en_i(en_i), .period_i(period_i),
        .adc_req_o(adc_req_o), .adc_valid_i(adc_valid_i), .adc_data_i(adc_data_i),
        .adc_value_o(adc_value_o), .coef_wr_i(coef_wr_i), .coef_addr_i(coef_addr_i),
        .coef_data_i(coef_data_i), .a1_o(a1_o), .a0_o(a0_o), .b0_o(b0_o), .b1_o(b1_o),
        .b2_o(b2_o), .clk_en_PID_o(clk_en_PID_o), .pid_val_i(pid_val_i), .duty_o(duty_o),
        .duty_valid_o(duty_valid_o), .adc_timeout_o(adc_timeout_o), .overrun_o(overrun_o)
    );

    // Model: sample windows are scheduled arithmetically from the enable cycle and period.
    int            k;
    bit            running;
    int            e_start;
    int            per;
    int            busy_end;
    int            pend_v;
    int            pend_cap;
    bit            sreq [NSLOT];
    bit            sto  [NSLOT];
    bit            e_stb, e_dv, e_ov;
    logic [AW-1:0] e_duty, e_val;
    logic [RW-1:0] shadow_m [5];
    logic [RW-1:0] active_m [5];
    int            lat_mode, lat_fix;
    int            n_cmp, n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("adc_req", 32'(adc_req_o), 32'(sreq[k]));
        chk("timeout", 32'(adc_timeout_o), 32'(sto[k]));
        chk("strobe", 32'(clk_en_PID_o), 32'(e_stb));
        chk("duty_valid", 32'(duty_valid_o), 32'(e_dv));
        chk("overrun", 32'(overrun_o), 32'(e_ov));
        chk("duty", 32'(duty_o), 32'(e_duty));
        chk("adc_value", 32'(adc_value_o), 32'(e_val));
        chk("a1", 32'(a1_o), 32'(active_m[0]));
        chk("a0", 32'(a0_o), 32'(active_m[1]));
        chk("b0", 32'(b0_o), 32'(active_m[2]));
        chk("b1", 32'(b1_o), 32'(active_m[3]));
        chk("b2", 32'(b2_o), 32'(active_m[4]));
    endtask

    function automatic int duty_of(input int p);
        if (p >= 0) return 0;
        return (-p > 255) ? 255 : -p;
    endfunction

    function automatic int pick_pid();
        case ($urandom_range(0, 7))
            0: return -100;
            1: return 50;
            2: return -256;
            3: return 255;
            4: return -1;
            5: return 0;
            default: return int'($urandom_range(0, 511)) - 256;
        endcase
    endfunction

    task automatic model_reset();
        running  = 1'b0;
        busy_end = -1;
        pend_v   = -1;
        pend_cap = -1;
        e_stb = 1'b0; e_dv = 1'b0; e_ov = 1'b0;
        e_duty = '0; e_val = '0;
        for (int i = 0; i < 5; i++) begin
            shadow_m[i] = '0;
            active_m[i] = '0;
        end
        for (int j = k; j < k + 24 && j < NSLOT; j++) begin
            sreq[j] = 1'b0;
            sto[j]  = 1'b0;
        end
    endtask

    // One clock: check this cycle's outputs, drive this cycle's inputs, predict the next cycle.
    task automatic step(input bit en_want);
        int            p;
        int            lat;
        logic [AW-1:0] dat;
        logic          wr;
        logic [2:0]    addr;
        logic [RW-1:0] cd;
        @(posedge clk_i);
        #1;
        k++;
        check_outputs();

        p    = pick_pid();
        dat  = AW'($urandom);
        wr   = ($urandom_range(0, 3) == 0);
        addr = 3'($urandom_range(0, 7));
        cd   = RW'($urandom);
        en_i        = en_want;
        adc_data_i  = dat;
        pid_val_i   = (AW + 1)'(p);
        coef_wr_i   = wr;
        coef_addr_i = addr;
        coef_data_i = cd;
        if (pend_v == k) adc_valid_i = 1'b1;
        else             adc_valid_i = !sreq[k] && ($urandom_range(0, 3) == 0);

        e_stb = 1'b0; e_dv = 1'b0; e_ov = 1'b0;
        if (!en_want) begin
            running  = 1'b0;
            pend_v   = -1;
            pend_cap = -1;
            busy_end = -1;
            for (int j = k + 1; j < k + 16; j++) begin
                sreq[j] = 1'b0;
                sto[j]  = 1'b0;
            end
        end else if (!running) begin
            running = 1'b1;
            e_start = k;
        end else begin
            if (pend_v == k) begin
                e_val    = dat;
                e_stb    = 1'b1;
                pend_cap = k + 2;
                pend_v   = -1;
            end
            if (pend_cap == k) begin
                e_duty   = AW'(duty_of(p));
                e_dv     = 1'b1;
                pend_cap = -1;
                $display("sample cyc=%0d pid=%0d duty=%0d", k + 1, p, duty_of(p));
            end
            if ((k - e_start) % (per + 1) == 0) begin
                if (k <= busy_end) begin
                    e_ov = 1'b1;
                end else begin
                    for (int i = 0; i < 5; i++) active_m[i] = shadow_m[i];
                    lat = (lat_mode != 0) ? int'($urandom_range(1, TO + 2)) : lat_fix;
                    if (lat <= TO) begin
                        for (int j = 1; j <= lat; j++) sreq[k + j] = 1'b1;
                        pend_v   = k + lat;
                        busy_end = k + lat + 2;
                    end else begin
                        for (int j = 1; j <= TO; j++) sreq[k + j] = 1'b1;
                        sto[k + TO + 1] = 1'b1;
                        busy_end = k + TO;
                        $display("adc timeout expected cyc=%0d", k + TO + 1);
                    end
                end
            end
        end
        if (wr && addr < 3'd5) shadow_m[addr] = cd;
    endtask

    // One enabled run at a fixed period, with one enable drop while a request is outstanding.
    task automatic run_phase(input int p, input int mode, input int fix, input int ncyc);
        bit dropped;
        dropped   = 1'b0;
        per       = p;
        period_i  = PW'(p);
        lat_mode  = mode;
        lat_fix   = fix;
        step(1'b0);
        step(1'b0);
        for (int c = 0; c < ncyc; c++) begin
            if (!dropped && c > ncyc / 2 && sreq[k + 1]) begin
                dropped = 1'b1;
                step(1'b0);
                step(1'b0);
            end else begin
                step(1'b1);
            end
        end
        step(1'b0);
    endtask

    initial begin
        int w;
        n_cmp = 0; n_bad = 0; k = 0;
        per = 9; lat_mode = 0; lat_fix = 2;
        for (int j = 0; j < NSLOT; j++) begin
            sreq[j] = 1'b0;
            sto[j]  = 1'b0;
        end
        rstn_i = 1'b0; en_i = 1'b0; period_i = '0;
        adc_valid_i = 1'b0; adc_data_i = '0; coef_wr_i = 1'b0;
        coef_addr_i = '0; coef_data_i = '0; pid_val_i = '0;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk_i);
        rstn_i = 1'b1;

        run_phase(9, 0, 2, 200);
        run_phase(9, 1, 0, 300);
        run_phase(1, 0, 3, 120);
        run_phase(0, 1, 0, 150);
        run_phase(4, 0, 6, 120);
        run_phase(3, 1, 0, 300);

        // Asynchronous reset while the PID step strobe is high.
        per = 9; period_i = PW'(9); lat_mode = 0; lat_fix = 2;
        step(1'b0);
        w = 0;
        while (!e_stb && w < 200) begin
            step(1'b1);
            w++;
        end
        step(1'b1);
        chk("pre_reset_strobe", 32'(clk_en_PID_o), 32'd1);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("rst_strobe", 32'(clk_en_PID_o), 32'd0);
        chk("rst_req", 32'(adc_req_o), 32'd0);
        chk("rst_duty", 32'(duty_o), 32'd0);
        chk("rst_value", 32'(adc_value_o), 32'd0);
        chk("rst_coefs", 32'({a1_o, a0_o, b0_o, b1_o, b2_o}), 32'd0);
        chk("rst_pulses", 32'({duty_valid_o, adc_timeout_o, overrun_o}), 32'd0);
        en_i = 1'b0; coef_wr_i = 1'b0; adc_valid_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        run_phase(2, 1, 0, 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
